// File: rtl/uart_rx_pkg.sv
// Shared types and default sizing for the UART receive buffer.
// Error tags are stored next to each frame so software sees which byte was bad.
package uart_rx_pkg;

  localparam int RX_DATA_W = 12;
  localparam int RX_DEPTH  = 32;
  localparam int PTR_W     = $clog2(RX_DEPTH);

  typedef struct packed {
    logic frame;
    logic parity;
  } rx_err_t;

  typedef struct packed {
    rx_err_t               err;
    logic [RX_DATA_W-1:0]  data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Character-timeout timer: counts idle cycles while data waits in the buffer
// and latches an IRQ until the next push, pop or flush.
module uart_rx_idle_timer
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 activity_i,
  input  logic                 empty_i,
  input  logic [TIMEOUT_W-1:0] timeout_cyc_i,
  output logic                 irq_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 irq_q, irq_d;

  // The IRQ is raised from the next count so it appears after exactly timeout_cyc_i idle edges.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (activity_i || empty_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (activity_i) begin
      irq_d = 1'b0;
    end else if ((timeout_cyc_i != '0) && (cnt_d == timeout_cyc_i)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receive buffer: DEPTH-entry circular FIFO of tagged frames, or a single
// holding register when FIFO mode is off. Provides status, overrun and IRQs.
module uart_rx_fifo_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = RX_DATA_W,
  parameter int DEPTH     = RX_DEPTH,
  parameter int TIMEOUT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_en_i,
  input  logic                     fifo_en_i,
  input  logic                     flush_i,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [1:0]               wr_err_i,
  input  logic                     rd_req_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [1:0]               rd_err_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overrun_o,
  input  logic                     overrun_clr_i,
  input  logic [$clog2(DEPTH):0]   thresh_i,
  output logic                     thresh_irq_o,
  input  logic [TIMEOUT_W-1:0]     timeout_cyc_i,
  output logic                     timeout_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    rx_err_t           err;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d, cap;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_err_q;
  logic              rd_valid_q, overrun_q, overrun_d, fifo_en_q;
  logic              flush, empty, full, push, pop, push_ok, overrun_evt;

  // In bypass mode every pointer is pinned to entry 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p, input logic fifo_mode);
    return fifo_mode ? AW'(p + 1'b1) : '0;
  endfunction

  assign flush       = flush_i | (fifo_en_i != fifo_en_q);
  assign cap         = fifo_en_q ? CW'(DEPTH) : CW'(1);
  assign empty       = (count_q == '0);
  assign full        = (count_q == cap);
  assign push        = wr_valid_i & rx_en_i & ~flush;
  assign pop         = rd_req_i & ~empty & ~flush;
  assign push_ok     = push & (~full | pop);
  assign overrun_evt = push & full & ~pop;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    overrun_d = overrun_evt | (overrun_q & ~overrun_clr_i);
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wp_d = ptr_inc(wp_q, fifo_en_q);
      if (pop)     rp_d = ptr_inc(rp_q, fifo_en_q);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_err_q   <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      fifo_en_q  <= 1'b1;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      fifo_en_q  <= fifo_en_i;
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem_q[rp_q].data;
        rd_err_q  <= mem_q[rp_q].err;
      end
    end
  end

  // Storage has no reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= {wr_err_i, wr_data_i};
  end

  uart_rx_idle_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_idle_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .activity_i    (push_ok | pop | flush),
    .empty_i       (empty),
    .timeout_cyc_i (timeout_cyc_i),
    .irq_o         (timeout_irq_o)
  );

  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;
  assign rd_valid_o   = rd_valid_q;
  assign count_o      = count_q;
  assign empty_o      = empty;
  assign full_o       = full;
  assign overrun_o    = overrun_q;
  assign thresh_irq_o = (thresh_i != '0) && (count_q >= thresh_i);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Scoreboard bench for uart_rx_fifo_param: pushed frames queue up as expectations
// and are compared when rd_valid_o reports the popped entry.
module tb_uart_rx_fifo_param;

  localparam int DATA_W    = 12;
  localparam int DEPTH     = 32;
  localparam int TIMEOUT_W = 16;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rx_en_i, fifo_en_i, flush_i, wr_valid_i, rd_req_i, overrun_clr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic [1:0]        wr_err_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [1:0]        rd_err_o;
  logic              rd_valid_o, empty_o, full_o, overrun_o, thresh_irq_o, timeout_irq_o;
  logic [CW-1:0]     count_o, thresh_i;
  logic [TIMEOUT_W-1:0] timeout_cyc_i;

  int checks = 0;
  int errors = 0;
  logic [13:0] sb[$];
  logic [13:0] exp_e;
  logic [11:0] last_rd = '0;

  uart_rx_fifo_param #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i), .rx_en_i (rx_en_i), .fifo_en_i (fifo_en_i),
    .flush_i (flush_i), .wr_valid_i (wr_valid_i), .wr_data_i (wr_data_i),
    .wr_err_i (wr_err_i), .rd_req_i (rd_req_i), .rd_data_o (rd_data_o),
    .rd_err_o (rd_err_o), .rd_valid_o (rd_valid_o), .count_o (count_o),
    .empty_o (empty_o), .full_o (full_o), .overrun_o (overrun_o),
    .overrun_clr_i (overrun_clr_i), .thresh_i (thresh_i),
    .thresh_irq_o (thresh_irq_o), .timeout_cyc_i (timeout_cyc_i),
    .timeout_irq_o (timeout_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({rd_data_o, rd_err_o, rd_valid_o, count_o, overrun_o, timeout_irq_o, full_o, empty_o} !== {12'h0, 2'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state got data=%h cnt=%0d v=%b ovr=%b full=%b empty=%b tirq=%b exp all zero with empty=1",
               rd_data_o, count_o, rd_valid_o, overrun_o, full_o, empty_o, timeout_irq_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] vals [3];
    vals[0] = 12'h0A1; vals[1] = 12'h0B2; vals[2] = 12'h0C3;
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = vals[i]; wr_err_i = 2'(i);
      sb.push_back({2'(i), vals[i]});
      tick();
    end
    wr_valid_i = 1'b0;
    checks++;
    if (count_o !== 6'd3 || empty_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_count got cnt=%0d empty=%b exp cnt=3 empty=0", count_o, empty_o);
    end
    for (int i = 0; i < 3; i++) begin
      rd_req_i = 1'b1;
      tick();
      exp_e = sb.pop_front();
      last_rd = exp_e[11:0];
      checks++;
      if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e) begin
        errors++;
        $display("[TB] FAIL basic_pop%0d got v=%b %h exp v=1 %h", i, rd_valid_o, {rd_err_o, rd_data_o}, exp_e);
      end
    end
    rd_req_i = 1'b0;
    tick();
    checks++;
    if (rd_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_drained got v=%b empty=%b exp v=0 empty=1", rd_valid_o, empty_o);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h100 + i); wr_err_i = 2'(i);
      sb.push_back({2'(i), 12'(12'h100 + i)});
      tick();
    end
    wr_valid_i = 1'b0;
    checks++;
    if (full_o !== 1'b1 || count_o !== 6'd32 || overrun_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovr_fill got full=%b cnt=%0d ovr=%b exp 1 32 0", full_o, count_o, overrun_o);
    end
    wr_valid_i = 1'b1; wr_data_i = 12'h5A5; wr_err_i = 2'b11;
    tick();
    wr_valid_i = 1'b0;
    checks++;
    if (full_o !== 1'b1 || count_o !== 6'd32 || overrun_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_drop got full=%b cnt=%0d ovr=%b exp 1 32 1", full_o, count_o, overrun_o);
    end
    wr_valid_i = 1'b1; overrun_clr_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_set_wins got %b exp 1", overrun_o);
    end
    tick();
    overrun_clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovr_clear got %b exp 0", overrun_o);
    end
    rd_req_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      exp_e = sb.pop_front();
      last_rd = exp_e[11:0];
      checks++;
      if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e) begin
        errors++;
        $display("[TB] FAIL ovr_pop%0d got v=%b %h exp v=1 %h", i, rd_valid_o, {rd_err_o, rd_data_o}, exp_e);
      end
    end
    rd_req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h300 + i); wr_err_i = 2'b00;
      sb.push_back({2'b00, 12'(12'h300 + i)});
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      wr_valid_i = 1'b1; rd_req_i = 1'b1;
      wr_data_i = 12'(i * 37 + 5); wr_err_i = 2'(i >> 1);
      sb.push_back({2'(i >> 1), 12'(i * 37 + 5)});
      tick();
      exp_e = sb.pop_front();
      last_rd = exp_e[11:0];
      checks++;
      if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e || count_o !== 6'd5) begin
        errors++;
        $display("[TB] FAIL b2b_cyc%0d got v=%b %h cnt=%0d exp v=1 %h cnt=5",
                 i, rd_valid_o, {rd_err_o, rd_data_o}, count_o, exp_e);
      end
    end
    wr_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_e = sb.pop_front();
      last_rd = exp_e[11:0];
      checks++;
      if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e) begin
        errors++;
        $display("[TB] FAIL b2b_drain%0d got %h exp %h", i, {rd_err_o, rd_data_o}, exp_e);
      end
    end
    rd_req_i = 1'b0;
    tick();
  endtask

  task automatic test_empty_edges();
    wr_valid_i = 1'b1; rd_req_i = 1'b1; wr_data_i = 12'h777; wr_err_i = 2'b10;
    sb.push_back({2'b10, 12'h777});
    tick();
    wr_valid_i = 1'b0; rd_req_i = 1'b0;
    checks++;
    if (count_o !== 6'd1 || rd_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_pushpop got cnt=%0d v=%b exp cnt=1 v=0", count_o, rd_valid_o);
    end
    rd_req_i = 1'b1;
    tick();
    exp_e = sb.pop_front();
    last_rd = exp_e[11:0];
    checks++;
    if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e) begin
      errors++;
      $display("[TB] FAIL empty_pop got v=%b %h exp v=1 %h", rd_valid_o, {rd_err_o, rd_data_o}, exp_e);
    end
    tick();
    rd_req_i = 1'b0;
    checks++;
    if (rd_valid_o !== 1'b0 || count_o !== 6'd0) begin
      errors++;
      $display("[TB] FAIL empty_underflow got v=%b cnt=%0d exp v=0 cnt=0", rd_valid_o, count_o);
    end
  endtask

  task automatic test_irqs();
    thresh_i = 6'd4; timeout_cyc_i = 16'd10;
    for (int i = 0; i < 2; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h600 + i); wr_err_i = 2'b01;
      sb.push_back({2'b01, 12'(12'h600 + i)});
      tick();
    end
    wr_valid_i = 1'b0;
    repeat (9) tick();
    checks++;
    if (timeout_irq_o !== 1'b0 || thresh_irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_idle9 got tirq=%b thirq=%b exp 0 0", timeout_irq_o, thresh_irq_o);
    end
    tick();
    checks++;
    if (timeout_irq_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_idle10 got %b exp 1", timeout_irq_o);
    end
    repeat (3) tick();
    checks++;
    if (timeout_irq_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_hold got %b exp 1", timeout_irq_o);
    end
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    exp_e = sb.pop_front();
    last_rd = exp_e[11:0];
    checks++;
    if (timeout_irq_o !== 1'b0 || {rd_err_o, rd_data_o} !== exp_e) begin
      errors++;
      $display("[TB] FAIL irq_popclr got tirq=%b %h exp 0 %h", timeout_irq_o, {rd_err_o, rd_data_o}, exp_e);
    end
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h680 + i); wr_err_i = 2'b00;
      sb.push_back({2'b00, 12'(12'h680 + i)});
      tick();
      checks++;
      if (thresh_irq_o !== (sb.size() >= 4)) begin
        errors++;
        $display("[TB] FAIL thresh_cnt%0d got %b exp %b", sb.size(), thresh_irq_o, sb.size() >= 4);
      end
    end
    wr_valid_i = 1'b0;
    timeout_cyc_i = '0;
    rd_req_i = 1'b1;
    while (sb.size() > 0) begin
      tick();
      exp_e = sb.pop_front();
      last_rd = exp_e[11:0];
      checks++;
      if ({rd_err_o, rd_data_o} !== exp_e) begin
        errors++;
        $display("[TB] FAIL irq_drain got %h exp %h", {rd_err_o, rd_data_o}, exp_e);
      end
    end
    rd_req_i = 1'b0;
    thresh_i = '0;
    tick();
    checks++;
    if (thresh_irq_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL thresh_zero got thirq=%b empty=%b exp 0 1", thresh_irq_o, empty_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h700 + i); wr_err_i = 2'b00;
      tick();
    end
    flush_i = 1'b1; rd_req_i = 1'b1; wr_data_i = 12'h009;
    tick();
    flush_i = 1'b0; rd_req_i = 1'b0; wr_valid_i = 1'b0;
    checks++;
    if (count_o !== 6'd0 || empty_o !== 1'b1 || rd_valid_o !== 1'b0 || rd_data_o !== last_rd) begin
      errors++;
      $display("[TB] FAIL flush got cnt=%0d empty=%b v=%b data=%h exp 0 1 0 %h",
               count_o, empty_o, rd_valid_o, rd_data_o, last_rd);
    end
  endtask

  task automatic test_bypass();
    fifo_en_i = 1'b0;
    tick(); tick();
    wr_valid_i = 1'b1; wr_data_i = 12'h111; wr_err_i = 2'b01;
    sb.push_back({2'b01, 12'h111});
    tick();
    wr_data_i = 12'h222; wr_err_i = 2'b10;
    tick();
    wr_valid_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1 || count_o !== 6'd1 || full_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byp_ovr got ovr=%b cnt=%0d full=%b exp 1 1 1", overrun_o, count_o, full_o);
    end
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    exp_e = sb.pop_front();
    checks++;
    if (rd_valid_o !== 1'b1 || {rd_err_o, rd_data_o} !== exp_e) begin
      errors++;
      $display("[TB] FAIL byp_pop got v=%b %h exp v=1 %h", rd_valid_o, {rd_err_o, rd_data_o}, exp_e);
    end
    fifo_en_i = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h800 + i);
      tick();
    end
    wr_valid_i = 1'b0;
    checks++;
    if (count_o !== 6'd3) begin
      errors++;
      $display("[TB] FAIL mode_prefill got cnt=%0d exp 3", count_o);
    end
    fifo_en_i = 1'b0;
    tick(); tick();
    checks++;
    if (count_o !== 6'd0 || overrun_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mode_flush got cnt=%0d ovr=%b exp 0 1", count_o, overrun_o);
    end
    fifo_en_i = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 2; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 12'(12'h900 + i); wr_err_i = 2'b11;
      tick();
    end
    rd_req_i = 1'b1; wr_data_i = 12'hABC;
    tick(); tick();
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({rd_data_o, rd_err_o, rd_valid_o, count_o, overrun_o, timeout_irq_o, thresh_irq_o, full_o, empty_o} !== {12'h0, 2'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL async_reset got data=%h err=%b v=%b cnt=%0d ovr=%b exp all zero with empty=1",
               rd_data_o, rd_err_o, rd_valid_o, count_o, overrun_o);
    end
    wr_valid_i = 1'b0; rd_req_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; rx_en_i = 1'b1; fifo_en_i = 1'b1; flush_i = 1'b0;
    wr_valid_i = 1'b0; wr_data_i = '0; wr_err_i = '0; rd_req_i = 1'b0;
    overrun_clr_i = 1'b0; thresh_i = '0; timeout_cyc_i = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_empty_edges();
    test_irqs();
    test_flush();
    test_bypass();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
